// File: rtl/dma_ch_sequencer.sv
// rtl/dma_ch_sequencer.sv - single-channel DMA beat sequencer with pause/stop/trigger control
// Optional trigger-out handshake after the last beat: define DMACH_TRIGOUT_EN.
module dma_ch_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable_cmd,
    input  logic             disable_cmd,
    input  logic             pause_cmd,
    input  logic             resume_cmd,
    input  logic             stop_cmd,
    input  logic             use_src_trigin,
    input  logic             src_trigin,
    input  logic             src_trigin_sw,
    input  logic [2:0]       x_type,
    input  logic [2:0]       transize,
    input  logic [CNT_W-1:0] srcxsize,
    input  logic [CNT_W-1:0] desxsize,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      des_addr,
    input  logic [15:0]      src_xaddr_inc,
    input  logic [15:0]      des_xaddr_inc,
    output logic             beat_req,
    output logic [31:0]      beat_src,
    output logic [31:0]      beat_des,
    output logic [2:0]       beat_size,
    output logic             beat_fill,
    input  logic             beat_ack,
    input  logic             beat_err,
    output logic             ch_busy,
    output logic             ch_paused,
    output logic             stat_done,
    output logic             stat_err,
`ifdef DMACH_TRIGOUT_EN
    output logic             trigout_req,
    input  logic             trigout_ack,
`endif
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TRIG,
        S_ISSUE,
        S_PAUSED,
        S_TRIGOUT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            resume_state;
    logic              pend_pause;
    logic              pend_stop;
    logic [15:0]       src_inc;
    logic [15:0]       des_inc;

    logic              abort;
    logic              trig;
    logic              legal;
    logic [CNT_W-1:0]  load_cnt;
    logic [31:0]       src_next;
    logic [31:0]       des_next;

    assign abort    = stop_cmd | disable_cmd;
    assign trig     = src_trigin | src_trigin_sw;
    assign legal    = ((x_type == 3'b001) || (x_type == 3'b011)) && !transize[2];
    assign load_cnt = (x_type == 3'b011) ? desxsize : srcxsize;
    // Increment is in beat units: sign-extend, then scale by the beat size.
    assign src_next = beat_src + ({{16{src_inc[15]}}, src_inc} << beat_size);
    assign des_next = beat_des + ({{16{des_inc[15]}}, des_inc} << beat_size);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            resume_state <= S_IDLE;
            pend_pause   <= 1'b0;
            pend_stop    <= 1'b0;
            src_inc      <= '0;
            des_inc      <= '0;
            beat_req     <= 1'b0;
            beat_src     <= '0;
            beat_des     <= '0;
            beat_size    <= '0;
            beat_fill    <= 1'b0;
            ch_busy      <= 1'b0;
            ch_paused    <= 1'b0;
            stat_done    <= 1'b0;
            stat_err     <= 1'b0;
            remaining    <= '0;
`ifdef DMACH_TRIGOUT_EN
            trigout_req  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable_cmd && !abort) begin
                        beat_src   <= src_addr;
                        beat_des   <= des_addr;
                        src_inc    <= src_xaddr_inc;
                        des_inc    <= des_xaddr_inc;
                        beat_size  <= transize;
                        beat_fill  <= (x_type == 3'b011);
                        stat_done  <= 1'b0;
                        stat_err   <= 1'b0;
                        pend_pause <= 1'b0;
                        pend_stop  <= 1'b0;
                        if (!legal) begin
                            stat_err  <= 1'b1;
                            remaining <= '0;
                        end else if (load_cnt == '0) begin
                            stat_done <= 1'b1;
                            remaining <= '0;
                        end else begin
                            remaining <= load_cnt;
                            ch_busy   <= 1'b1;
                            if (use_src_trigin) begin
                                state <= S_WAIT_TRIG;
                            end else begin
                                state    <= S_ISSUE;
                                beat_req <= 1'b1;
                            end
                        end
                    end
                end
                S_WAIT_TRIG: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        ch_busy <= 1'b0;
                    end else if (pause_cmd) begin
                        state        <= S_PAUSED;
                        resume_state <= S_WAIT_TRIG;
                        ch_paused    <= 1'b1;
                    end else if (trig) begin
                        state    <= S_ISSUE;
                        beat_req <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // Commands arriving mid-beat are remembered until the ack.
                    if (abort)     pend_stop  <= 1'b1;
                    if (pause_cmd) pend_pause <= 1'b1;
                    if (beat_ack) begin
                        if (beat_err) begin
                            state      <= S_IDLE;
                            beat_req   <= 1'b0;
                            ch_busy    <= 1'b0;
                            stat_err   <= 1'b1;
                            stat_done  <= 1'b0;
                            pend_pause <= 1'b0;
                            pend_stop  <= 1'b0;
                        end else begin
                            remaining <= remaining - CNT_ONE;
                            beat_des  <= des_next;
                            if (!beat_fill) beat_src <= src_next;
                            if (abort || pend_stop) begin
                                state      <= S_IDLE;
                                beat_req   <= 1'b0;
                                ch_busy    <= 1'b0;
                                pend_pause <= 1'b0;
                                pend_stop  <= 1'b0;
                            end else if (remaining == CNT_ONE) begin
                                beat_req   <= 1'b0;
                                pend_pause <= 1'b0;
`ifdef DMACH_TRIGOUT_EN
                                state       <= S_TRIGOUT;
                                trigout_req <= 1'b1;
`else
                                state     <= S_IDLE;
                                ch_busy   <= 1'b0;
                                stat_done <= 1'b1;
`endif
                            end else if (pause_cmd || pend_pause) begin
                                state        <= S_PAUSED;
                                resume_state <= S_ISSUE;
                                beat_req     <= 1'b0;
                                ch_paused    <= 1'b1;
                                pend_pause   <= 1'b0;
                            end
                        end
                    end
                end
                S_PAUSED: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        ch_busy   <= 1'b0;
                        ch_paused <= 1'b0;
                    end else if (resume_cmd) begin
                        state     <= resume_state;
                        ch_paused <= 1'b0;
                        beat_req  <= (resume_state == S_ISSUE);
                    end
                end
`ifdef DMACH_TRIGOUT_EN
                S_TRIGOUT: begin
                    if (abort) begin
                        state       <= S_IDLE;
                        ch_busy     <= 1'b0;
                        trigout_req <= 1'b0;
                    end else if (trigout_ack) begin
                        state       <= S_IDLE;
                        ch_busy     <= 1'b0;
                        trigout_req <= 1'b0;
                        stat_done   <= 1'b1;
                    end
                end
`endif
                default: begin
                    state    <= S_IDLE;
                    beat_req <= 1'b0;
                    ch_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
